// File: rtl/sync_event_arbiter.sv
// Collects rising edges from asynchronous event lines and presents them one at
// a time on a valid/ready port, using round-robin order and sticky overflow flags.
module sync_event_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic              evt_ready,
    input  logic              clr_ovf,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] ovf_flag
);

    logic [NUM_CH-1:0] sync_reg [SYNC_STAGES];
    logic [NUM_CH-1:0] hist_reg;
    logic [NUM_CH-1:0] pend_reg;
    logic [NUM_CH-1:0] ovf_reg;
    logic              evt_valid_reg;
    logic [CH_W-1:0]   evt_ch_reg;
    logic [CH_W-1:0]   last_gnt_reg;

    logic [NUM_CH-1:0] edge_det;
    logic [NUM_CH-1:0] gnt_onehot;
    logic [NUM_CH-1:0] pend_next;
    logic [NUM_CH-1:0] ovf_next;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   cand_idx;
    logic              gnt_found;
    logic              slot_free;
    logic              grant;

    // Plain flop chain: the first stage is the only consumer of sig_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= '0;
            end
        end else begin
            sync_reg[0] <= sig_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
        end
    end

    assign slot_free = ~evt_valid_reg | evt_ready;
    assign grant     = slot_free & gnt_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign edge_det[gi]   = sync_reg[SYNC_STAGES-1][gi] & ~hist_reg[gi];
            assign gnt_onehot[gi] = grant && (gnt_idx == CH_W'(gi));
        end
    endgenerate

    // Round-robin search starting just after the previous winner.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_idx = CH_W'((int'(last_gnt_reg) + k) % NUM_CH);
            if (!gnt_found && pend_reg[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // A new edge beats both the grant clear and the overflow clear.
    assign pend_next = (pend_reg & ~gnt_onehot) | edge_det;
    assign ovf_next  = (clr_ovf ? '0 : ovf_reg) | (edge_det & pend_reg & ~gnt_onehot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg      <= '0;
            pend_reg      <= '0;
            ovf_reg       <= '0;
            evt_valid_reg <= 1'b0;
            evt_ch_reg    <= '0;
            last_gnt_reg  <= CH_W'(NUM_CH - 1);
        end else begin
            hist_reg <= sync_reg[SYNC_STAGES-1];
            pend_reg <= pend_next;
            ovf_reg  <= ovf_next;
            if (slot_free) begin
                if (grant) begin
                    evt_valid_reg <= 1'b1;
                    evt_ch_reg    <= gnt_idx;
                    last_gnt_reg  <= gnt_idx;
                end else begin
                    evt_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign evt_valid = evt_valid_reg;
    assign evt_ch    = evt_ch_reg;
    assign pend      = pend_reg;
    assign ovf_flag  = ovf_reg;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Directed bench for sync_event_arbiter: reset, latency, round-robin bursts,
// backpressure with overflow, clear priority and mid-operation reset.
module tb_sync_event_arbiter;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic [3:0] sig_in;
    logic       evt_ready;
    logic       clr_ovf;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic [3:0] pend;
    logic [3:0] ovf_flag;

    int checks;
    int errors;

    sync_event_arbiter #(.NUM_CH(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .pend      (pend),
        .ovf_flag  (ovf_flag)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] pat);
        sig_in = pat;
        steps(4);
        sig_in = '0;
        steps(6);
    endtask

    logic [1:0] order_a [4];
    logic [1:0] order_b [4];
    int         n_evt;
    int         n_bad;

    initial begin
        checks    = 0;
        errors    = 0;
        clk       = 1'b0;
        clk_run   = 1'b0;
        rst       = 1'b1;
        evt_ready = 1'b1;
        clr_ovf   = 1'b0;
        sig_in    = 4'($urandom_range(15, 0));
        order_a   = '{2'd0, 2'd1, 2'd2, 2'd3};
        order_b   = '{2'd2, 2'd3, 2'd0, 2'd1};

        // Reset with no clock running
        #20;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_ch",    32'(evt_ch),    32'd0);
        check("rst_pend",  32'(pend),      32'd0);
        check("rst_ovf",   32'(ovf_flag),  32'd0);

        sig_in  = '0;
        clk_run = 1'b1;
        apply_reset();
        steps(3);

        // Single event on channel 2
        sig_in = 4'b0100;
        steps(2);
        check("single_pend_e2", 32'(pend), 32'h0);
        step();
        check("single_pend_e3",  32'(pend),      32'h4);
        check("single_valid_e3", 32'(evt_valid), 32'd0);
        step();
        check("single_valid_e4", 32'(evt_valid), 32'd1);
        check("single_ch_e4",    32'(evt_ch),    32'd2);
        check("single_pend_e4",  32'(pend),      32'h0);
        step();
        check("single_valid_e5", 32'(evt_valid), 32'd0);
        check("single_ch_hold",  32'(evt_ch),    32'd2);
        sig_in = '0;
        steps(4);

        // Burst from reset: 0,1,2,3 back to back
        apply_reset();
        sig_in = 4'hF;
        steps(3);
        check("burst_a_pend", 32'(pend), 32'hF);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("burst_a_valid%0d", i), 32'(evt_valid), 32'd1);
            check($sformatf("burst_a_ch%0d", i),    32'(evt_ch),    32'(order_a[i]));
        end
        step();
        check("burst_a_idle", 32'(evt_valid), 32'd0);

        // Make channel 1 the last winner, then burst again: 2,3,0,1
        sig_in = '0;
        steps(4);
        sig_in = 4'b0010;
        steps(4);
        check("setup_ch1", 32'(evt_ch), 32'd1);
        step();
        sig_in = '0;
        steps(4);
        sig_in = 4'hF;
        steps(3);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("burst_b_valid%0d", i), 32'(evt_valid), 32'd1);
            check($sformatf("burst_b_ch%0d", i),    32'(evt_ch),    32'(order_b[i]));
        end
        step();
        check("burst_b_idle", 32'(evt_valid), 32'd0);
        sig_in = '0;
        steps(4);

        // Backpressure and overflow on channel 1
        apply_reset();
        evt_ready = 1'b0;
        pulse(4'b0010);
        check("bp1_valid", 32'(evt_valid), 32'd1);
        check("bp1_ch",    32'(evt_ch),    32'd1);
        check("bp1_pend",  32'(pend),      32'h0);
        pulse(4'b0010);
        check("bp2_ch",   32'(evt_ch),   32'd1);
        check("bp2_pend", 32'(pend),     32'h2);
        check("bp2_ovf",  32'(ovf_flag), 32'h0);
        pulse(4'b0010);
        check("bp3_valid", 32'(evt_valid), 32'd1);
        check("bp3_ch",    32'(evt_ch),    32'd1);
        check("bp3_pend",  32'(pend),      32'h2);
        check("bp3_ovf",   32'(ovf_flag),  32'h2);
        evt_ready = 1'b1;
        n_evt = 0;
        n_bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (evt_valid && evt_ready) begin
                n_evt++;
                if (evt_ch != 2'd1) n_bad++;
            end
            step();
        end
        check("bp_drain_count", 32'(n_evt), 32'd2);
        check("bp_drain_bad",   32'(n_bad), 32'd0);
        check("bp_ovf_sticky",  32'(ovf_flag), 32'h2);

        // Clear in the same cycle as a channel-0 overflow
        evt_ready = 1'b0;
        pulse(4'b0001);
        pulse(4'b0001);
        check("clr_pre_pend", 32'(pend), 32'h1);
        sig_in = 4'b0001;
        steps(2);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("clr_same_cycle", 32'(ovf_flag), 32'h1);
        step();
        sig_in = '0;
        steps(6);
        check("clr_hold", 32'(ovf_flag), 32'h1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("clr_alone", 32'(ovf_flag), 32'h0);

        // Mid-operation reset with an event presented and two pending
        apply_reset();
        evt_ready = 1'b0;
        sig_in = 4'b0001;
        steps(4);
        sig_in = 4'b1011;
        steps(3);
        check("mid_pre_valid", 32'(evt_valid), 32'd1);
        check("mid_pre_pend",  32'(pend),      32'hA);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_ch",    32'(evt_ch),    32'd0);
        check("mid_rst_pend",  32'(pend),      32'h0);
        check("mid_rst_ovf",   32'(ovf_flag),  32'h0);
        sig_in = 4'b0001;
        steps(2);
        evt_ready = 1'b1;
        rst = 1'b0;
        n_evt = 0;
        n_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (evt_valid) begin
                n_evt++;
                if (evt_ch != 2'd0) n_bad++;
            end
        end
        check("mid_post_count", 32'(n_evt), 32'd1);
        check("mid_post_bad",   32'(n_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
